// File: rtl/tb_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_run_sequencer
//
// Run controller for the arithmetic testbench. It walks the
// randomiser/driver/monitor/scoreboard chain through four phases:
//   CLEAR : hold the testbench in reset for RESET_CYCLES cycles
//   RUN   : enable stimulus for exactly N cycles
//   DRAIN : keep everything live for L cycles so in-flight results land
//   DONE  : freeze the scoreboard, then capture its counters
// All logic runs on the rising edge of the DUT clock.
//
// Ports:
//   clk              DUT clock
//   reset            synchronous, active-high reset
//   i_start          start request (level, sampled every cycle)
//   i_abort          abort request (level, sampled every cycle)
//   i_num_samples    stimulus cycle count N, latched on accepted start
//   i_latency        drain cycle count, latched on accepted start (0 -> 1)
//   i_event_ctr      scoreboard event counter
//   i_data_ctr       scoreboard data counter
//   o_tb_reset       reset to the testbench
//   o_tb_enable      enable to the testbench
//   o_tb_freeze      freeze to the scoreboard
//   o_busy           run in progress (CLEAR, RUN or DRAIN)
//   o_done           captured results are valid
//   o_aborted        last run was ended by abort
//   o_pass           last run completed with zero events and no abort
//   o_result_events  captured event count
//   o_result_data    captured data count
//   o_state          current state encoding, for debug
//
// Handshake: i_start / i_abort are plain level requests with no ready
// return. A start is accepted only in IDLE or DONE and only with a non-zero
// sample count; o_busy tells the host when a start would be ignored. An
// abort is honoured only while o_busy is high. All outputs are registered
// and Moore-decoded from the state they accompany, so each one moves on the
// cycle after the input that caused the transition.
// ---------------------------------------------------------------------------
module tb_run_sequencer #(
    parameter int RESET_CYCLES = 4,
    parameter int LAT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [31:0]          i_num_samples,
    input  logic [LAT_WIDTH-1:0] i_latency,
    input  logic [31:0]          i_event_ctr,
    input  logic [31:0]          i_data_ctr,
    output logic                 o_tb_reset,
    output logic                 o_tb_enable,
    output logic                 o_tb_freeze,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic                 o_pass,
    output logic [31:0]          o_result_events,
    output logic [31:0]          o_result_data,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Control outputs that are a pure function of the state being entered.
    typedef struct packed {
        logic tb_reset;
        logic tb_enable;
        logic tb_freeze;
        logic busy;
    } ctrl_t;

    localparam logic [31:0] CLEAR_LAST = 32'(RESET_CYCLES - 1);

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_IDLE:  c.tb_reset = 1'b1;
            ST_CLEAR: begin
                c.tb_reset = 1'b1;
                c.busy     = 1'b1;
            end
            ST_RUN: begin
                c.tb_enable = 1'b1;
                c.busy      = 1'b1;
            end
            ST_DRAIN: c.busy = 1'b1;
            ST_DONE:  c.tb_freeze = 1'b1;
            default:  c.tb_reset = 1'b1;
        endcase
        return c;
    endfunction

    state_t               state;
    ctrl_t                ctrl;
    logic [31:0]          cnt;          // shared phase counter, reset on each phase entry
    logic [31:0]          num_q;        // latched N
    logic [LAT_WIDTH-1:0] lat_q;        // latched L, never 0 once latched
    logic                 cap_pending;  // first DONE cycle: capture at its end
    logic                 done_q;
    logic                 aborted_q;
    logic                 pass_q;
    logic [31:0]          res_events_q;
    logic [31:0]          res_data_q;

    logic        start_ok;
    logic        accept;
    logic        abort_hit;
    logic [31:0] drain_last;

    assign start_ok  = i_start && (i_num_samples != 32'd0);
    assign accept    = start_ok && ((state == ST_IDLE) || (state == ST_DONE));
    assign abort_hit = i_abort &&
                       ((state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN));
    // lat_q is at least 1 whenever DRAIN is reachable, so this never wraps in use.
    assign drain_last = {{(32-LAT_WIDTH){1'b0}}, lat_q} - 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ctrl         <= ctrl_of(ST_IDLE);
            cnt          <= '0;
            num_q        <= '0;
            lat_q        <= '0;
            cap_pending  <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            pass_q       <= 1'b0;
            res_events_q <= '0;
            res_data_q   <= '0;
        end else if (accept) begin
            // Start wins over a simultaneous abort: abort_hit is never set
            // in the two states where a start can be accepted.
            state       <= ST_CLEAR;
            ctrl        <= ctrl_of(ST_CLEAR);
            cnt         <= '0;
            num_q       <= i_num_samples;
            lat_q       <= (i_latency == '0) ? LAT_WIDTH'(1) : i_latency;
            cap_pending <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else if (abort_hit) begin
            // Results are still captured one cycle into DONE, so an aborted
            // run reports the partial counts seen so far.
            state       <= ST_DONE;
            ctrl        <= ctrl_of(ST_DONE);
            cnt         <= '0;
            cap_pending <= 1'b1;
            aborted_q   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                end
                ST_CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        state <= ST_RUN;
                        ctrl  <= ctrl_of(ST_RUN);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    // Compare against N-1 so N = 0xFFFFFFFF needs no 33rd bit.
                    if (cnt == num_q - 32'd1) begin
                        state <= ST_DRAIN;
                        ctrl  <= ctrl_of(ST_DRAIN);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == drain_last) begin
                        state       <= ST_DONE;
                        ctrl        <= ctrl_of(ST_DONE);
                        cnt         <= '0;
                        cap_pending <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    // Freeze has been visible to the scoreboard for a full
                    // cycle by now, so its counters are stable.
                    if (cap_pending) begin
                        cap_pending  <= 1'b0;
                        res_events_q <= i_event_ctr;
                        res_data_q   <= i_data_ctr;
                        done_q       <= 1'b1;
                        pass_q       <= (i_event_ctr == 32'd0) && !aborted_q;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ctrl        <= ctrl_of(ST_IDLE);
                    cnt         <= '0;
                    cap_pending <= 1'b0;
                end
            endcase
        end
    end

    assign o_tb_reset      = ctrl.tb_reset;
    assign o_tb_enable     = ctrl.tb_enable;
    assign o_tb_freeze     = ctrl.tb_freeze;
    assign o_busy          = ctrl.busy;
    assign o_done          = done_q;
    assign o_aborted       = aborted_q;
    assign o_pass          = pass_q;
    assign o_result_events = res_events_q;
    assign o_result_data   = res_data_q;
    assign o_state         = state;

endmodule

// File: tb/tb_tb_run_sequencer.sv
module tb_tb_run_sequencer;

    localparam int R = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_num_samples;
    logic [7:0]  i_latency;
    logic [31:0] i_event_ctr;
    logic [31:0] i_data_ctr;
    logic        o_tb_reset;
    logic        o_tb_enable;
    logic        o_tb_freeze;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic        o_pass;
    logic [31:0] o_result_events;
    logic [31:0] o_result_data;
    logic [2:0]  o_state;

    tb_run_sequencer #(.RESET_CYCLES(R), .LAT_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_num_samples   (i_num_samples),
        .i_latency       (i_latency),
        .i_event_ctr     (i_event_ctr),
        .i_data_ctr      (i_data_ctr),
        .o_tb_reset      (o_tb_reset),
        .o_tb_enable     (o_tb_enable),
        .o_tb_freeze     (o_tb_freeze),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_aborted       (o_aborted),
        .o_pass          (o_pass),
        .o_result_events (o_result_events),
        .o_result_data   (o_result_data),
        .o_state         (o_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Check state plus the Moore outputs that follow from it.
    task automatic check_ctrl(input string tag, input logic [2:0] st);
        check32({tag, " state"}, 32'(o_state), 32'(st));
        check1({tag, " tb_reset"},  o_tb_reset,  (st == 3'd0) || (st == 3'd1));
        check1({tag, " tb_enable"}, o_tb_enable, st == 3'd2);
        check1({tag, " tb_freeze"}, o_tb_freeze, st == 3'd4);
        check1({tag, " busy"},      o_busy,      (st >= 3'd1) && (st <= 3'd3));
    endtask

    // Nominal timeline, start sampled at cycle 0.
    function automatic logic [2:0] exp_state(input int k, input int n, input int leff);
        if (k <= R)               return 3'd1;
        else if (k <= R + n)      return 3'd2;
        else if (k <= R + n + leff) return 3'd3;
        else                      return 3'd4;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] n;
        logic [7:0]  lat;
        int          leff;      // hand-computed max(lat,1)
        logic [31:0] ev;
        logic [31:0] data;
        logic        exp_pass;
        logic        pulse;     // fire a start pulse mid-RUN
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int last;
        string tag;
        last = R + int'(v.n) + v.leff + 2;
        tag = $sformatf("vec%0d", idx);
        i_event_ctr   = v.ev;
        i_data_ctr    = v.data;
        i_num_samples = v.n;
        i_latency     = v.lat;
        i_start       = 1'b1;
        exp_q.push_back(v.ev);
        exp_q.push_back(v.data);
        for (int k = 1; k <= last; k++) begin
            tick();
            i_start = v.pulse && (k == R + 2);
            check_ctrl(tag, exp_state(k, int'(v.n), v.leff));
            check1({tag, " done"},    o_done,    k >= last);
            check1({tag, " aborted"}, o_aborted, 1'b0);
            check1({tag, " pass"},    o_pass,    (k >= last) ? v.exp_pass : 1'b0);
            if (k == last) begin
                check32({tag, " events"}, o_result_events, exp_q.pop_front());
                check32({tag, " data"},   o_result_data,   exp_q.pop_front());
            end
        end
        for (int h = 0; h < 3; h++) begin
            tick();
            check_ctrl({tag, " hold"}, 3'd4);
            check1({tag, " hold done"}, o_done, 1'b1);
            check32({tag, " hold events"}, o_result_events, v.ev);
            check32({tag, " hold data"},   o_result_data,   v.data);
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs[4];

    initial begin
        reset = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_num_samples = '0;
        i_latency = '0;
        i_event_ctr = '0;
        i_data_ctr = '0;

        vecs[0] = '{n: 32'd10, lat: 8'd2, leff: 2, ev: 32'd0, data: 32'd10,     exp_pass: 1'b1, pulse: 1'b0};
        vecs[1] = '{n: 32'd5,  lat: 8'd0, leff: 1, ev: 32'd3, data: 32'd5,      exp_pass: 1'b0, pulse: 1'b1};
        vecs[2] = '{n: 32'd1,  lat: 8'd3, leff: 3, ev: 32'd0, data: 32'h1234,   exp_pass: 1'b1, pulse: 1'b0};
        vecs[3] = '{n: 32'd3,  lat: 8'd7, leff: 7, ev: 32'd9, data: 32'hABCD01, exp_pass: 1'b0, pulse: 1'b1};

        // Reset then idle.
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_ctrl("idle", 3'd0);
            check1("idle done", o_done, 1'b0);
        end
        check32("idle events", o_result_events, 32'd0);
        check32("idle data",   o_result_data,   32'd0);
        check1("idle pass",    o_pass,          1'b0);

        // Abort in IDLE is ignored.
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        check_ctrl("idle abort", 3'd0);
        check1("idle abort aborted", o_aborted, 1'b0);

        // Start with N=0 is ignored.
        i_num_samples = 32'd0;
        i_latency = 8'd2;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_ctrl("n0", 3'd0);
            tick();
        end

        // Table-driven nominal runs, back to back from IDLE/DONE.
        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Abort at cycle 50 of an N=1000 run, issued from DONE.
        i_num_samples = 32'd1000;
        i_latency = 8'd2;
        i_event_ctr = 32'd7;
        i_data_ctr = 32'd50;
        i_start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            i_start = 1'b0;
            i_abort = (k == 50);
            check_ctrl("abrt run", exp_state(k, 1000, 2));
        end
        tick();                                  // cycle 51
        i_abort = 1'b0;
        check_ctrl("abrt c51", 3'd4);
        check1("abrt c51 aborted", o_aborted, 1'b1);
        check1("abrt c51 done",    o_done,    1'b0);
        tick();                                  // cycle 52
        check1("abrt c52 done",    o_done,    1'b1);
        check1("abrt c52 pass",    o_pass,    1'b0);
        check32("abrt c52 events", o_result_events, 32'd7);
        check32("abrt c52 data",   o_result_data,   32'd50);
        for (int k = 53; k <= 59; k++) begin
            tick();
            check_ctrl("abrt hold", 3'd4);
            check1("abrt hold aborted", o_aborted, 1'b1);
        end
        tick();                                  // cycle 60: start + abort together
        i_num_samples = 32'd2;
        i_latency = 8'd1;
        i_event_ctr = 32'd0;
        i_data_ctr = 32'd2;
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();                                  // cycle 61 = restart cycle 1
        i_start = 1'b0;
        i_abort = 1'b0;
        check_ctrl("restart c61", 3'd1);
        check1("restart aborted", o_aborted, 1'b0);
        check1("restart done",    o_done,    1'b0);
        for (int j = 2; j <= R + 2 + 1 + 2; j++) begin
            tick();
            check_ctrl("restart", exp_state(j, 2, 1));
            check1("restart done", o_done, j >= R + 5);
        end
        check1("restart pass",    o_pass,          1'b1);
        check32("restart events", o_result_events, 32'd0);
        check32("restart data",   o_result_data,   32'd2);

        // Synchronous reset during RUN.
        i_num_samples = 32'd100;
        i_latency = 8'd2;
        i_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            i_start = 1'b0;
            check_ctrl("rst run", exp_state(k, 100, 2));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_ctrl("rst mid", 3'd0);
        check1("rst mid done",    o_done,    1'b0);
        check1("rst mid aborted", o_aborted, 1'b0);
        check1("rst mid pass",    o_pass,    1'b0);
        check32("rst mid events", o_result_events, 32'd0);
        check32("rst mid data",   o_result_data,   32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ctrl("rst after", 3'd0);
        end

        check32("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
